// File: rtl/fact_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fact_pkg
// Purpose  : Shared types and widths for the factorial-engine scheduler.
//            N_W   - operand width handed to the engine
//            RES_W - engine result width
//            TMR_W - width of the WAIT-state timeout timer
//            state_t - scheduler FSM states
// Revision : 1.0 - initial release
// ============================================================================
package fact_pkg;

  localparam int N_W   = 8;
  localparam int RES_W = 32;
  localparam int TMR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fact_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : fact_rr_pick
// Purpose  : Combinational round-robin selector. Picks the first set request
//            bit strictly after last_grant, wrapping around to bit 0.
// Ports    : req        in  NUM_REQ  level requests
//            last_grant in  IDX_W    index served most recently
//            valid      out 1        any request present
//            idx        out IDX_W    selected requester
// Revision : 1.0 - initial release
// ============================================================================
module fact_rr_pick
  import fact_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  // Two passes: first look only above last_grant, then fall back to the
  // lowest set bit overall, which realises the wrap-around.
  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) > last_grant)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fact_sched.sv
`default_nettype none
// ============================================================================
// Module   : fact_sched
// Purpose  : Shares one factorial engine between NUM_REQ requesters. Grants
//            round-robin, issues one operation at a time, waits for the engine
//            (with timeout) and returns a one-cycle ack plus response.
// Ports    : clk          in  1          clock, rising edge
//            rst          in  1          asynchronous reset, active low
//            req          in  NUM_REQ    level requests, held until ack
//            req_n        in  NUM_REQ*8  operands, slice i = [8i+7:8i]
//            ack          out NUM_REQ    one-hot completion pulse
//            rsp_result   out 32         result, valid with ack
//            rsp_err      out 1          engine error or timeout
//            rsp_timeout  out 1          response produced by timeout
//            busy         out 1          FSM not idle
//            fact_n       out 8          operand to engine
//            fact_go      out 1          engine start strobe
//            fact_done    in  1          engine completion
//            fact_err     in  1          engine error
//            fact_result  in  32         engine result
// Revision : 1.0 - initial release
// ============================================================================
module fact_sched
  import fact_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     ack,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [N_W-1:0]         fact_n,
  output logic                   fact_go,
  input  logic                   fact_done,
  input  logic                   fact_err,
  input  logic [RES_W-1:0]       fact_result
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [N_W-1:0]       fact_n_q, fact_n_d;
  logic                 fact_go_q, fact_go_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [RES_W-1:0]     rsp_result_q, rsp_result_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 busy_q, busy_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [N_W-1:0]       req_n_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_n_arr[g] = req_n[g*N_W +: N_W];
  end

  fact_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    fact_n_d      = fact_n_q;
    ack_d         = '0;
    rsp_result_d  = rsp_result_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          fact_n_d = req_n_arr[pick_idx];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Engine completion wins over a timeout landing in the same cycle.
        if (fact_done) begin
          rsp_result_d  = fact_result;
          rsp_err_d     = fact_err;
          rsp_timeout_d = 1'b0;
          ack_d         = NUM_REQ'(1) << idx_q;
          state_d       = ST_RESP;
        end else if (timer_q == TMR_LAST) begin
          rsp_result_d  = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          ack_d         = NUM_REQ'(1) << idx_q;
          state_d       = ST_RESP;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_RESP: begin
        last_grant_d = idx_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    fact_go_d = (state_d == ST_ISSUE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      timer_q       <= '0;
      fact_n_q      <= '0;
      fact_go_q     <= 1'b0;
      ack_q         <= '0;
      rsp_result_q  <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      fact_n_q      <= fact_n_d;
      fact_go_q     <= fact_go_d;
      ack_q         <= ack_d;
      rsp_result_q  <= rsp_result_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign ack         = ack_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign fact_n      = fact_n_q;
  assign fact_go     = fact_go_q;

endmodule
`default_nettype wire

// File: tb/tb_fact_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fact_sched
// Purpose  : Self-checking bench for fact_sched. Instance A uses the default
//            TIMEOUT; instance B uses TIMEOUT=8 for expiry/coincidence cases.
//            Expected responses are queued when requests are raised and are
//            compared when the DUT pulses ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fact_sched;

  localparam int NR   = 4;
  localparam int TO_B = 8;

  typedef struct {
    logic [NR-1:0] ack;
    logic [31:0]   res;
    logic          err;
    logic          tmo;
    logic [7:0]    n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic [NR-1:0]   req_a = '0;
  logic [NR*8-1:0] req_n_a = '0;
  logic [NR-1:0]   ack_a;
  logic [31:0]     rsp_result_a;
  logic            rsp_err_a, rsp_timeout_a, busy_a, fact_go_a;
  logic [7:0]      fact_n_a;
  logic            fact_done_a = 1'b0, fact_err_a = 1'b0;
  logic [31:0]     fact_result_a = '0;

  // Instance B
  logic [NR-1:0]   req_b = '0;
  logic [NR*8-1:0] req_n_b = '0;
  logic [NR-1:0]   ack_b;
  logic [31:0]     rsp_result_b;
  logic            rsp_err_b, rsp_timeout_b, busy_b, fact_go_b;
  logic [7:0]      fact_n_b;
  logic            fact_done_b = 1'b0, fact_err_b = 1'b0;
  logic [31:0]     fact_result_b = '0;

  fact_sched #(.NUM_REQ(NR)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_n(req_n_a), .ack(ack_a),
    .rsp_result(rsp_result_a), .rsp_err(rsp_err_a), .rsp_timeout(rsp_timeout_a),
    .busy(busy_a), .fact_n(fact_n_a), .fact_go(fact_go_a),
    .fact_done(fact_done_a), .fact_err(fact_err_a), .fact_result(fact_result_a)
  );

  fact_sched #(.NUM_REQ(NR), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_n(req_n_b), .ack(ack_b),
    .rsp_result(rsp_result_b), .rsp_err(rsp_err_b), .rsp_timeout(rsp_timeout_b),
    .busy(busy_b), .fact_n(fact_n_b), .fact_go(fact_go_b),
    .fact_done(fact_done_b), .fact_err(fact_err_b), .fact_result(fact_result_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] fact32(input logic [7:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  function automatic exp_t mk(input int idx, input logic [7:0] n, input bit tmo);
    exp_t e;
    e.ack = NR'(1) << idx;
    e.n   = n;
    e.tmo = tmo;
    e.err = tmo ? 1'b1 : (n > 8'd12);
    e.res = tmo ? 32'd0 : fact32(n);
    return e;
  endfunction

  exp_t qa[$];
  exp_t qb[$];

  // Engine models: done arrives LAT cycles after the fact_go cycle; LAT=0
  // means the engine never answers. The engine shares the scheduler reset.
  int         lat_a = 10, lat_b = 0;
  int         cnt_a = 0, cnt_b = 0;
  logic [7:0] nl_a = '0, nl_b = '0;

  always @(negedge clk) begin
    fact_done_a = 1'b0;
    fact_done_b = 1'b0;
    if (!rst) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (cnt_a > 0) begin
        cnt_a--;
        if (cnt_a == 0) begin
          fact_done_a   = 1'b1;
          fact_result_a = fact32(nl_a);
          fact_err_a    = (nl_a > 8'd12);
        end
      end
      if (fact_go_a) begin nl_a = fact_n_a; cnt_a = lat_a; end
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          fact_done_b   = 1'b1;
          fact_result_b = fact32(nl_b);
          fact_err_b    = (nl_b > 8'd12);
        end
      end
      if (fact_go_b) begin nl_b = fact_n_b; cnt_b = lat_b; end
    end
  end

  // Scoreboard / monitors
  int   cyc = 0;
  int   go_cnt_a = 0;
  int   go_cyc_b = 0;
  exp_t ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_rsp(input string who, input exp_t e, input logic [NR-1:0] a,
                           input logic [31:0] res, input logic err, input logic tmo,
                           input logic [7:0] n);
    chk({who, "_ack"}, 32'(a), 32'(e.ack));
    chk({who, "_result"}, res, e.res);
    chk({who, "_err"}, 32'(err), 32'(e.err));
    chk({who, "_timeout"}, 32'(tmo), 32'(e.tmo));
    chk({who, "_fact_n"}, 32'(n), 32'(e.n));
  endtask

  always @(negedge clk) begin
    if (fact_go_a) go_cnt_a++;
    if (fact_go_b) go_cyc_b = cyc;
    if (ack_a != '0) begin
      if (qa.size() == 0) chk("a_unexpected_ack", 32'(ack_a), 32'd0);
      else begin
        ea = qa.pop_front();
        check_rsp("a", ea, ack_a, rsp_result_a, rsp_err_a, rsp_timeout_a, fact_n_a);
      end
    end
    if (ack_b != '0) begin
      if (qb.size() == 0) chk("b_unexpected_ack", 32'(ack_b), 32'd0);
      else begin
        eb = qb.pop_front();
        check_rsp("b", eb, ack_b, rsp_result_b, rsp_err_b, rsp_timeout_b, fact_n_b);
      end
    end
  end

  // Bounded wait for the next ack on one instance; returns the ack seen.
  task automatic wait_ack(input bit use_b, input int max_cyc, output logic [NR-1:0] a);
    int n;
    n = 0;
    a = '0;
    while (a == '0 && n < max_cyc) begin
      @(negedge clk);
      a = use_b ? ack_b : ack_a;
      n++;
    end
    if (a == '0) chk(use_b ? "b_ack_seen" : "a_ack_seen", 32'(a != '0), 32'd1);
  endtask

  logic [NR-1:0] a;
  int            g0;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ack_a", 32'(ack_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_go_a", 32'(fact_go_a), 32'd0);
    chk("rst_fact_n_a", 32'(fact_n_a), 32'd0);
    chk("rst_result_a", rsp_result_a, 32'd0);
    chk("rst_err_a", 32'(rsp_err_a), 32'd0);
    chk("rst_timeout_a", 32'(rsp_timeout_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fairness: all four held, grants 0,1,2,3,0
    lat_a   = 10;
    req_n_a = {8'd6, 8'd5, 8'd4, 8'd3};
    qa.push_back(mk(0, 8'd3, 1'b0));
    qa.push_back(mk(1, 8'd4, 1'b0));
    qa.push_back(mk(2, 8'd5, 1'b0));
    qa.push_back(mk(3, 8'd6, 1'b0));
    qa.push_back(mk(0, 8'd3, 1'b0));
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ack(1'b0, 40, a);
    req_a = '0;
    repeat (2) @(negedge clk);

    // Single request, n=5, engine latency 10
    g0      = go_cnt_a;
    req_n_a = {8'd0, 8'd0, 8'd0, 8'd5};
    qa.push_back(mk(0, 8'd5, 1'b0));
    req_a = 4'b0001;
    wait_ack(1'b0, 40, a);
    req_a &= ~a;
    chk("single_go_pulses", 32'(go_cnt_a - g0), 32'd1);
    repeat (3) @(negedge clk);
    chk("hold_result_a", rsp_result_a, 32'd120);
    chk("idle_busy_a", 32'(busy_a), 32'd0);

    // Engine error, n=13
    lat_a   = 4;
    req_n_a = {8'd0, 8'd0, 8'd13, 8'd0};
    qa.push_back(mk(1, 8'd13, 1'b0));
    req_a = 4'b0010;
    wait_ack(1'b0, 40, a);
    req_a &= ~a;
    repeat (2) @(negedge clk);

    // Instance B: done one cycle before expiry
    lat_b   = 7;
    req_n_b = {8'd0, 8'd0, 8'd0, 8'd5};
    qb.push_back(mk(0, 8'd5, 1'b0));
    req_b = 4'b0001;
    wait_ack(1'b1, 40, a);
    req_b &= ~a;
    chk("b_lat_early", 32'(cyc - go_cyc_b), 32'd8);
    repeat (2) @(negedge clk);

    // Instance B: done exactly in the expiry cycle (8th WAIT cycle)
    lat_b   = 8;
    req_n_b = {8'd0, 8'd0, 8'd0, 8'd6};
    qb.push_back(mk(0, 8'd6, 1'b0));
    req_b = 4'b0001;
    wait_ack(1'b1, 40, a);
    req_b &= ~a;
    chk("b_lat_coincide", 32'(cyc - go_cyc_b), 32'(TO_B + 1));
    repeat (2) @(negedge clk);

    // Instance B: engine never answers -> timeout after 8 WAIT cycles
    lat_b   = 0;
    req_n_b = {8'd0, 8'd0, 8'd0, 8'd7};
    qb.push_back(mk(0, 8'd7, 1'b1));
    req_b = 4'b0001;
    wait_ack(1'b1, 40, a);
    req_b &= ~a;
    chk("b_lat_timeout", 32'(cyc - go_cyc_b), 32'(TO_B + 1));
    repeat (3) @(negedge clk);
    chk("hold_timeout_b", 32'(rsp_timeout_b), 32'd1);
    chk("hold_err_b", 32'(rsp_err_b), 32'd1);

    // Reset during WAIT on requester 2: no ack, outputs drop at once
    lat_a   = 10;
    req_n_a = {8'd0, 8'd4, 8'd0, 8'd0};
    req_a   = 4'b0100;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy_a", 32'(busy_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy_a", 32'(busy_a), 32'd0);
    chk("mid_rst_go_a", 32'(fact_go_a), 32'd0);
    chk("mid_rst_ack_a", 32'(ack_a), 32'd0);
    req_a = '0;
    repeat (3) @(negedge clk);
    chk("mid_rst_fact_n_a", 32'(fact_n_a), 32'd0);
    chk("mid_rst_result_a", rsp_result_a, 32'd0);
    rst = 1'b1;

    // After reset, requester 0 has priority over requester 2
    req_n_a = {8'd0, 8'd3, 8'd0, 8'd2};
    qa.push_back(mk(0, 8'd2, 1'b0));
    qa.push_back(mk(2, 8'd3, 1'b0));
    req_a = 4'b0101;
    wait_ack(1'b0, 40, a);
    req_a &= ~a;
    wait_ack(1'b0, 40, a);
    req_a &= ~a;
    repeat (4) @(negedge clk);

    chk("a_pending", 32'(qa.size()), 32'd0);
    chk("b_pending", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
